// File: rtl/clock_core.sv
// clock_core: running HH:MM:SS time-of-day counter in BCD.
// A prescaler divides clk down to a one-second tick; the time advances
// digit by digit with BCD carries and a 23:59:59 -> 00:00:00 wrap.
// A level-sensitive load port presets hours and minutes (seconds -> 00)
// and flags invalid digit sets through a sticky load_err.
// Optional alarm comparator: define CLOCK_CORE_ALARM_EN to add it.
module clock_core #(
  parameter int TICKS_PER_SEC = 32768,
  parameter int PRESC_W       = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  logic [1:0] i_hours_left,
  input  logic [3:0] i_hours_right,
  input  logic [2:0] i_minutes_left,
  input  logic [3:0] i_minutes_right,
`ifdef CLOCK_CORE_ALARM_EN
  input  logic [1:0] alarm_hours_left,
  input  logic [3:0] alarm_hours_right,
  input  logic [2:0] alarm_minutes_left,
  input  logic [3:0] alarm_minutes_right,
  input  logic       alarm_arm,
  input  logic       alarm_ack,
  output logic       alarm_out,
`endif
  output logic [1:0] o_hours_left,
  output logic [3:0] o_hours_right,
  output logic [2:0] o_minutes_left,
  output logic [3:0] o_minutes_right,
  output logic [2:0] o_seconds_left,
  output logic [3:0] o_seconds_right,
  output logic       sec_pulse,
  output logic       min_pulse,
  output logic       load_err
);

  // Terminal count of the prescaler, sized to the counter.
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

  // State registers
  logic [PRESC_W-1:0] presc_q,  presc_d;
  logic [1:0]         hr_l_q,   hr_l_d;
  logic [3:0]         hr_r_q,   hr_r_d;
  logic [2:0]         min_l_q,  min_l_d;
  logic [3:0]         min_r_q,  min_r_d;
  logic [2:0]         sec_l_q,  sec_l_d;
  logic [3:0]         sec_r_q,  sec_r_d;
  logic               sec_pulse_q, sec_pulse_d;
  logic               min_pulse_q, min_pulse_d;
  logic               load_err_q,  load_err_d;

  // Time one second after the current time
  logic [1:0] hr_l_adv;
  logic [3:0] hr_r_adv;
  logic [2:0] min_l_adv;
  logic [3:0] min_r_adv;
  logic [2:0] sec_l_adv;
  logic [3:0] sec_r_adv;

  logic tick;
  logic min_wrap;
  logic load_valid;

  // A tick only counts when no load is in progress; a coincident load wins.
  assign tick     = !load_en && (presc_q == PRESC_MAX);
  // Seconds are at 59, so the next advance rolls over into the minutes.
  assign min_wrap = (sec_r_q == 4'd9) && (sec_l_q == 3'd5);

  // Validate the incoming digits as a legal 24-hour HH:MM.
  always_comb begin
    load_valid = 1'b1;
    if (i_hours_left > 2'd2)                              load_valid = 1'b0;
    if (i_hours_right > 4'd9)                             load_valid = 1'b0;
    if ((i_hours_left == 2'd2) && (i_hours_right > 4'd3)) load_valid = 1'b0;
    if (i_minutes_left > 3'd5)                            load_valid = 1'b0;
    if (i_minutes_right > 4'd9)                           load_valid = 1'b0;
  end

  // BCD ripple of one second through all six digits.
  always_comb begin
    sec_r_adv = sec_r_q;
    sec_l_adv = sec_l_q;
    min_r_adv = min_r_q;
    min_l_adv = min_l_q;
    hr_r_adv  = hr_r_q;
    hr_l_adv  = hr_l_q;
    if (sec_r_q == 4'd9) begin
      sec_r_adv = 4'd0;
      if (sec_l_q == 3'd5) begin
        sec_l_adv = 3'd0;
        if (min_r_q == 4'd9) begin
          min_r_adv = 4'd0;
          if (min_l_q == 3'd5) begin
            min_l_adv = 3'd0;
            if ((hr_l_q == 2'd2) && (hr_r_q == 4'd3)) begin
              // 23 -> 00
              hr_l_adv = 2'd0;
              hr_r_adv = 4'd0;
            end else if (hr_r_q == 4'd9) begin
              // 09 -> 10, 19 -> 20
              hr_r_adv = 4'd0;
              hr_l_adv = hr_l_q + 2'd1;
            end else begin
              hr_r_adv = hr_r_q + 4'd1;
            end
          end else begin
            min_l_adv = min_l_q + 3'd1;
          end
        end else begin
          min_r_adv = min_r_q + 4'd1;
        end
      end else begin
        sec_l_adv = sec_l_q + 3'd1;
      end
    end else begin
      sec_r_adv = sec_r_q + 4'd1;
    end
  end

  // Next-state selection: load, tick or plain prescaler count.
  always_comb begin
    presc_d     = presc_q;
    hr_l_d      = hr_l_q;
    hr_r_d      = hr_r_q;
    min_l_d     = min_l_q;
    min_r_d     = min_r_q;
    sec_l_d     = sec_l_q;
    sec_r_d     = sec_r_q;
    sec_pulse_d = 1'b0;
    min_pulse_d = 1'b0;
    load_err_d  = load_err_q;
    if (load_en) begin
      // Holding load keeps the prescaler at 0, so the loaded time gets a
      // full first second once load_en drops.
      presc_d = '0;
      if (load_valid) begin
        hr_l_d     = i_hours_left;
        hr_r_d     = i_hours_right;
        min_l_d    = i_minutes_left;
        min_r_d    = i_minutes_right;
        sec_l_d    = 3'd0;
        sec_r_d    = 4'd0;
        load_err_d = 1'b0;
      end else begin
        // Invalid digits never reach the time registers.
        load_err_d = 1'b1;
      end
    end else if (tick) begin
      presc_d     = '0;
      hr_l_d      = hr_l_adv;
      hr_r_d      = hr_r_adv;
      min_l_d     = min_l_adv;
      min_r_d     = min_r_adv;
      sec_l_d     = sec_l_adv;
      sec_r_d     = sec_r_adv;
      sec_pulse_d = 1'b1;
      min_pulse_d = min_wrap;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // Register all state; asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q     <= '0;
      hr_l_q      <= 2'd0;
      hr_r_q      <= 4'd0;
      min_l_q     <= 3'd0;
      min_r_q     <= 4'd0;
      sec_l_q     <= 3'd0;
      sec_r_q     <= 4'd0;
      sec_pulse_q <= 1'b0;
      min_pulse_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      hr_l_q      <= hr_l_d;
      hr_r_q      <= hr_r_d;
      min_l_q     <= min_l_d;
      min_r_q     <= min_r_d;
      sec_l_q     <= sec_l_d;
      sec_r_q     <= sec_r_d;
      sec_pulse_q <= sec_pulse_d;
      min_pulse_q <= min_pulse_d;
      load_err_q  <= load_err_d;
    end
  end

`ifdef CLOCK_CORE_ALARM_EN
  logic alarm_q, alarm_d;
  logic alarm_match;

  // The alarm fires on the minute rollover that lands on the alarm HH:MM;
  // seconds are 00 by construction at that moment.
  assign alarm_match = (hr_l_adv  == alarm_hours_left)   &&
                       (hr_r_adv  == alarm_hours_right)  &&
                       (min_l_adv == alarm_minutes_left) &&
                       (min_r_adv == alarm_minutes_right);

  // Acknowledge or disarm beats a coincident set; loads never set it
  // because tick is suppressed while load_en is high.
  always_comb begin
    alarm_d = alarm_q;
    if (alarm_ack || !alarm_arm) begin
      alarm_d = 1'b0;
    end else if (tick && min_wrap && alarm_match) begin
      alarm_d = 1'b1;
    end
  end

  // Alarm flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm_out = alarm_q;
`endif

  assign o_hours_left    = hr_l_q;
  assign o_hours_right   = hr_r_q;
  assign o_minutes_left  = min_l_q;
  assign o_minutes_right = min_r_q;
  assign o_seconds_left  = sec_l_q;
  assign o_seconds_right = sec_r_q;
  assign sec_pulse       = sec_pulse_q;
  assign min_pulse       = min_pulse_q;
  assign load_err        = load_err_q;

endmodule

// File: tb/tb_clock_core.sv
// tb_clock_core: directed, table-driven bench for clock_core with
// TICKS_PER_SEC=4. Inputs change and outputs are sampled on negedge.
module tb_clock_core;

  localparam int TPS = 4;
  localparam int PW  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_en;
  logic [1:0] i_hl;
  logic [3:0] i_hr;
  logic [2:0] i_ml;
  logic [3:0] i_mr;
  logic [1:0] o_hl;
  logic [3:0] o_hr;
  logic [2:0] o_ml;
  logic [3:0] o_mr;
  logic [2:0] o_sl;
  logic [3:0] o_sr;
  logic       sec_pulse, min_pulse, load_err;
`ifdef CLOCK_CORE_ALARM_EN
  logic [1:0] a_hl;
  logic [3:0] a_hr;
  logic [2:0] a_ml;
  logic [3:0] a_mr;
  logic       alarm_arm, alarm_ack, alarm_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clock_core #(.TICKS_PER_SEC(TPS), .PRESC_W(PW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en),
    .i_hours_left(i_hl), .i_hours_right(i_hr),
    .i_minutes_left(i_ml), .i_minutes_right(i_mr),
`ifdef CLOCK_CORE_ALARM_EN
    .alarm_hours_left(a_hl), .alarm_hours_right(a_hr),
    .alarm_minutes_left(a_ml), .alarm_minutes_right(a_mr),
    .alarm_arm(alarm_arm), .alarm_ack(alarm_ack), .alarm_out(alarm_out),
`endif
    .o_hours_left(o_hl), .o_hours_right(o_hr),
    .o_minutes_left(o_ml), .o_minutes_right(o_mr),
    .o_seconds_left(o_sl), .o_seconds_right(o_sr),
    .sec_pulse(sec_pulse), .min_pulse(min_pulse), .load_err(load_err)
  );

  // Observed word: {hh, mm, ss, load_err, sec_pulse, min_pulse}
  logic [22:0] act;
  assign act = {o_hl, o_hr, o_ml, o_mr, o_sl, o_sr, load_err, sec_pulse, min_pulse};

  function automatic logic [22:0] ew(int hl, int hr, int ml, int mr, int sl, int sr,
                                     int err, int sp, int mp);
    return {2'(hl), 4'(hr), 3'(ml), 4'(mr), 3'(sl), 4'(sr), 1'(err), 1'(sp), 1'(mp)};
  endfunction

  typedef struct {
    logic        ld;
    logic [3:0]  hl, hr, ml, mr;
    int          idle;
    logic [22:0] exp;
  } vec_t;

  function automatic vec_t mk(logic ld, int hl, int hr, int ml, int mr, int idle,
                              logic [22:0] e);
    vec_t v;
    v.ld = ld; v.hl = 4'(hl); v.hr = 4'(hr); v.ml = 4'(ml); v.mr = 4'(mr);
    v.idle = idle; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_load(input int hl, input int hr, input int ml, input int mr);
    i_hl = 2'(hl); i_hr = 4'(hr); i_ml = 3'(ml); i_mr = 4'(mr);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  vec_t vecs[17];

  // Bound the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vecs[0]  = mk(1, 2, 3, 5, 9,   0, ew(2,3,5,9,0,0, 0,0,0));
    vecs[1]  = mk(0, 0, 0, 0, 0, 236, ew(2,3,5,9,5,9, 0,1,0));
    vecs[2]  = mk(0, 0, 0, 0, 0,   4, ew(0,0,0,0,0,0, 0,1,1));
    vecs[3]  = mk(1, 2, 9, 0, 0,   0, ew(0,0,0,0,0,0, 1,0,0));
    vecs[4]  = mk(0, 0, 0, 0, 0,   4, ew(0,0,0,0,0,1, 1,1,0));
    vecs[5]  = mk(1, 1, 2, 3, 4,   0, ew(1,2,3,4,0,0, 0,0,0));
    vecs[6]  = mk(1, 3, 0, 0, 0,   0, ew(1,2,3,4,0,0, 1,0,0));
    vecs[7]  = mk(1, 1, 9, 5, 9,   7, ew(1,9,5,9,0,1, 0,0,0));
    vecs[8]  = mk(1, 1, 9, 5, 9, 236, ew(1,9,5,9,5,9, 0,1,0));
    vecs[9]  = mk(0, 0, 0, 0, 0,   4, ew(2,0,0,0,0,0, 0,1,1));
    vecs[10] = mk(1, 0, 9, 5, 9, 240, ew(1,0,0,0,0,0, 0,1,1));
    vecs[11] = mk(1, 2, 4, 0, 0,   0, ew(1,0,0,0,0,0, 1,0,0));
    vecs[12] = mk(1, 1,10, 0, 0,   0, ew(1,0,0,0,0,0, 1,0,0));
    vecs[13] = mk(1, 0, 0, 6, 0,   0, ew(1,0,0,0,0,0, 1,0,0));
    vecs[14] = mk(1, 0, 0, 0,10,   0, ew(1,0,0,0,0,0, 1,0,0));
    vecs[15] = mk(1, 0, 0, 5, 9, 240, ew(0,1,0,0,0,0, 0,1,1));
    vecs[16] = mk(1, 0, 9, 0, 9,  40, ew(0,9,0,9,1,0, 0,1,0));

    load_en = 1'b0; i_hl = '0; i_hr = '0; i_ml = '0; i_mr = '0;
`ifdef CLOCK_CORE_ALARM_EN
    a_hl = 2'd1; a_hr = 4'd2; a_ml = 3'd3; a_mr = 4'd5;
    alarm_arm = 1'b0; alarm_ack = 1'b0;
`endif
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("reset_state", 32'(act), 32'(ew(0,0,0,0,0,0,0,0,0)));
`ifdef CLOCK_CORE_ALARM_EN
    check("reset_alarm", 32'(alarm_out), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Free run from reset: first second after 4 clocks, first minute after 240.
    repeat (3) @(negedge clk);
    check("presc_before_tick", 32'(act), 32'(ew(0,0,0,0,0,0,0,0,0)));
    @(negedge clk);
    check("first_second", 32'(act), 32'(ew(0,0,0,0,0,1,0,1,0)));
    @(negedge clk);
    check("sec_pulse_one_cycle", 32'(act), 32'(ew(0,0,0,0,0,1,0,0,0)));
    repeat (235) @(negedge clk);
    check("first_minute", 32'(act), 32'(ew(0,0,0,1,0,0,0,1,1)));
    $display("run 240 clks: %h:%h:%h sp=%b mp=%b", {o_hl, o_hr}, {o_ml, o_mr},
             {o_sl, o_sr}, sec_pulse, min_pulse);

    // Table of load/run vectors.
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].ld) drive_load(int'(vecs[i].hl), int'(vecs[i].hr),
                                 int'(vecs[i].ml), int'(vecs[i].mr));
      repeat (vecs[i].idle) @(negedge clk);
      $display("vec %0d: ld=%b in=%0d%0d:%0d%0d idle=%0d -> %h:%h:%h err=%b sp=%b mp=%b",
               i, vecs[i].ld, vecs[i].hl, vecs[i].hr, vecs[i].ml, vecs[i].mr,
               vecs[i].idle, {o_hl, o_hr}, {o_ml, o_mr}, {o_sl, o_sr},
               load_err, sec_pulse, min_pulse);
      check($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
    end

    // Load held across a would-be tick; first tick 4 clocks after release.
    drive_load(1, 2, 3, 4);
    repeat (3) @(negedge clk);
    load_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("hold_load_%0d", k), 32'(act), 32'(ew(1,2,3,4,0,0,0,0,0)));
    end
    load_en = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sec_pulse && n < 20);
    $display("resume: first sec_pulse after %0d clks", n);
    check("resume_latency", 32'(n), 32'd4);
    check("resume_time", 32'(act), 32'(ew(1,2,3,4,0,1,0,1,0)));

`ifdef CLOCK_CORE_ALARM_EN
    // Alarm at 12:35 fires on the minute rollover, clears on ack.
    alarm_arm = 1'b1;
    drive_load(1, 2, 3, 4);
    check("alarm_after_load", 32'(alarm_out), 32'd0);
    repeat (239) @(negedge clk);
    check("alarm_before_min", 32'(alarm_out), 32'd0);
    @(negedge clk);
    check("alarm_min_time", 32'(act), 32'(ew(1,2,3,5,0,0,0,1,1)));
    check("alarm_set", 32'(alarm_out), 32'd1);
    @(negedge clk);
    check("alarm_sticky", 32'(alarm_out), 32'd1);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    check("alarm_ack", 32'(alarm_out), 32'd0);
    drive_load(1, 2, 3, 5);
    check("alarm_no_load_trigger", 32'(alarm_out), 32'd0);
    $display("alarm sequence done: alarm_out=%b", alarm_out);
    alarm_arm = 1'b0;
`endif

    // Asynchronous reset mid-count with load_err set.
    drive_load(1, 2, 3, 4);
    repeat (224) @(negedge clk);
    check("pre_reset_time", 32'(act), 32'(ew(1,2,3,4,5,6,0,1,0)));
    drive_load(3, 0, 0, 0);
    check("pre_reset_err", 32'(act), 32'(ew(1,2,3,4,5,6,1,0,0)));
    #1 rst = 1'b0;
    #1;
    check("async_reset", 32'(act), 32'(ew(0,0,0,0,0,0,0,0,0)));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("after_reset_release", 32'(act), 32'(ew(0,0,0,0,0,0,0,0,0)));
    $display("reset check done: %h:%h:%h", {o_hl, o_hr}, {o_ml, o_mr}, {o_sl, o_sr});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clock_core.md
Name: clock_core

Overview:
- Running time-of-day counter downstream of the time-setting block; consumes its BCD digit outputs and its load/active strobe.
- Keeps HH:MM:SS in BCD using an internal prescaler that divides clk into a 1 s tick.
- Outputs the BCD digits to the display driver, plus second and minute pulses for downstream consumers.

Parameters:
- TICKS_PER_SEC, 32768, number of clk cycles per second; must be ≥2 (benches use 4).
- PRESC_W, 15, prescaler counter width; must satisfy 2^PRESC_W ≥ TICKS_PER_SEC.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- load_en  input  1  level; while high, time is loaded from the i_* digits
- i_hours_left  input  2  BCD tens of hours to load
- i_hours_right  input  4  BCD units of hours to load
- i_minutes_left  input  3  BCD tens of minutes to load
- i_minutes_right  input  4  BCD units of minutes to load
- o_hours_left  output  2  current tens of hours
- o_hours_right  output  4  current units of hours
- o_minutes_left  output  3  current tens of minutes
- o_minutes_right  output  4  current units of minutes
- o_seconds_left  output  3  current tens of seconds
- o_seconds_right  output  4  current units of seconds
- sec_pulse  output  1  one-cycle pulse each time the seconds value advances
- min_pulse  output  1  one-cycle pulse on the seconds wrap from 59 to 00
- load_err  output  1  sticky flag: the last load attempt carried invalid digits

Behaviour:
- Clock and reset: clk, with rst asynchronous and active-low. All flops are cleared by reset:
  - time 00:00:00
  - prescaler 0
  - sec_pulse, min_pulse and load_err all 0
- Asserting rst mid-count or mid-load returns the block to this state immediately.
- All outputs are registered.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 while load_en=0.
  - On the edge where prescaler==TICKS_PER_SEC-1: prescaler<=0, the time advances one second, and sec_pulse<=1 for exactly one cycle.
  - The new time and sec_pulse become visible in the same cycle.
- Advance arithmetic, applied per digit in BCD:
  - seconds_right 9->0 carries into seconds_left.
  - seconds_left 5->0 carries into minutes_right, and min_pulse<=1 in the same cycle as sec_pulse.
  - minutes_right 9->0 carries into minutes_left.
  - minutes_left 5->0 carries into the hours digits.
  - Hours wrap: 09->10, 19->20, 23->00.
  - 23:59:59 -> 00:00:00 in one tick, with both pulses asserted.
- Load validity: a load is valid when all of the following hold:
  - i_hours_left ≤2
  - i_hours_right ≤9
  - if i_hours_left==2, then i_hours_right ≤3
  - i_minutes_left ≤5
  - i_minutes_right ≤9
- Load, on every cycle with load_en=1:
  - prescaler<=0, sec_pulse<=0, min_pulse<=0.
  - If valid: hours and minutes <= i_* digits, seconds<=00, load_err<=0.
  - If invalid: time registers are held unchanged, load_err<=1.
  - Load has priority over a coincident tick; that tick is discarded.
- Resume after load:
  - On the first cycle with load_en=0, the prescaler starts from 0.
  - The first sec_pulse arrives TICKS_PER_SEC cycles after load_en falls, so the loaded minute gets a full first second.
- load_err:
  - Remains set through counting until the next valid load cycle.
  - Does not affect counting; the clock keeps running from the held time.
- Time-register invariant: the registers never hold a non-BCD or out-of-range value.

Optional Feature:
- Macro: CLOCK_CORE_ALARM_EN.
- When defined, the following ports are added:
  - alarm_hours_left (in, 2), alarm_hours_right (in, 4), alarm_minutes_left (in, 3), alarm_minutes_right (in, 4)
  - alarm_arm (in, 1)
  - alarm_ack (in, 1)
  - alarm_out (out, 1)
- Alarm set: alarm_out is set registered on the min_pulse cycle where alarm_arm=1 and the new HH:MM equals the alarm digits with seconds at 00.
- Alarm clear: alarm_out stays high until alarm_ack=1 or alarm_arm=0, then clears on the next edge.
- If a set and an ack occur in the same cycle, the ack wins.
- A load never triggers the alarm, even if it loads the alarm time.
- Reset value of alarm_out is 0.
- When the macro is undefined, these ports and the alarm logic are absent, and behaviour is otherwise identical.

Test Plan (TICKS_PER_SEC=4):
- Reset release, no load: 4 clks -> seconds 01 with sec_pulse high for 1 cycle; 240 clks -> 00:01:00 with min_pulse coincident with sec_pulse.
- load_en high 1 cycle with 23:59 valid, then free-run 240 clks -> 00:00:00 with both pulses in the same cycle; load_err=0.
- Load 2,9 (29:xx) -> time unchanged, load_err=1; then load 1,2,3,4 -> 12:34:00 and load_err=0.
- Hold load_en across a would-be tick (prescaler at 3) -> no sec_pulse and seconds stay 00; first sec_pulse exactly 4 clks after load_en falls.
- Assert rst mid-count at 12:34:56 -> all outputs 0 asynchronously, before the next edge.
- With CLOCK_CORE_ALARM_EN: alarm 12:35, armed, load 12:34 -> alarm_out rises on the 12:35:00 min_pulse cycle; alarm_ack -> alarm_out=0 on the next edge.
